// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and widths for the RSA key-generation blocks
package rsa_pkg;

  // Operand width used by the n/phi generators when they instantiate the multiplier
  localparam int RSA_WIDTH = 32;

  // Multiplier responder states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/shift_add_mult_if.sv
// rtl/shift_add_mult_if.sv - ready/done multiply handshake between initiator and multiplier
interface shift_add_mult_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);

  logic             mult_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             overflow;
  logic             mult_done;

  // Initiator side (n, phi generators, benches)
  modport master (
    output mult_ready, in1, in2,
    input  out, out_hi, overflow, mult_done
  );

  // Responder side (the multiplier)
  modport slave (
    input  mult_ready, in1, in2,
    output out, out_hi, overflow, mult_done
  );

endinterface

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - fixed-latency shift-and-add multiplier, one multiplier bit per cycle
module shift_add_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  shift_add_mult_if.slave        bus
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t        state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic               overflow_q, overflow_d;
  logic               mult_done_q, mult_done_d;
  logic [2*WIDTH-1:0] acc_next;

  // State register; asynchronous reset discards any computation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-datapath values; the final partial product is folded
  // straight into the result registers so done appears exactly WIDTH edges after the request
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    overflow_d  = overflow_q;
    mult_done_d = mult_done_q;
    acc_next    = b_q[0] ? (acc_q + a_q) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mult_ready) begin
          a_d     = {{WIDTH{1'b0}}, bus.in1};
          b_d     = bus.in2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A withdrawn request wins even on the last iteration
        if (!bus.mult_ready) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_next;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_d       = acc_next[WIDTH-1:0];
            out_hi_d    = acc_next[2*WIDTH-1:WIDTH];
            overflow_d  = |acc_next[2*WIDTH-1:WIDTH];
            mult_done_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        // Four-phase release: hold the result until the initiator drops its request
        if (!bus.mult_ready) begin
          mult_done_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand, accumulator, counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_hi_q    <= '0;
      overflow_q  <= 1'b0;
      mult_done_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      overflow_q  <= overflow_d;
      mult_done_q <= mult_done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.overflow  = overflow_q;
  assign bus.mult_done = mult_done_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed vector bench for shift_add_mult
module tb_shift_add_mult;

  localparam int W   = 32;
  localparam int LAT = 32;

  typedef struct {
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full request/response cycle: checks latency, result, then the release
  task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] elo, input logic [W-1:0] ehi,
                          input logic eovf, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    bus.in1        = x;
    bus.in2        = y;
    bus.mult_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in1 = $urandom;
    bus.in2 = $urandom;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.mult_done) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " out"},      64'(bus.out),      64'(elo));
    check({tag, " out_hi"},   64'(bus.out_hi),   64'(ehi));
    check({tag, " overflow"}, 64'(bus.overflow), 64'(eovf));
    @(negedge clk);
    bus.mult_ready = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done released"}, 64'(bus.mult_done), 64'd0);
    check({tag, " out kept"},      64'(bus.out),       64'(elo));
  endtask

  vec_t vecs [10];

  initial begin
    bit saw_done;
    bit unstable;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{32'd61,        32'd53,        32'h0000_0CA1, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
    vecs[3] = '{32'd0,         32'd12345,     32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'd12345,     32'd0,         32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'd2,         32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[7] = '{32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8] = '{32'd65535,     32'd65535,     32'hFFFE_0001, 32'h0000_0000, 1'b0};
    vecs[9] = '{32'd100000,    32'd100000,    32'h540B_E400, 32'h0000_0002, 1'b1};

    bus.mult_ready = 1'b0;
    bus.in1        = '0;
    bus.in2        = '0;
    reset_n        = 1'b1;
    #1;
    reset_n = 1'b0;
    #2;
    check("reset out",       64'(bus.out),       64'd0);
    check("reset out_hi",    64'(bus.out_hi),    64'd0);
    check("reset overflow",  64'(bus.overflow),  64'd0);
    check("reset mult_done", 64'(bus.mult_done), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_mult(vecs[i].in1, vecs[i].in2, vecs[i].lo, vecs[i].hi, vecs[i].ovf,
               $sformatf("vec%0d", i));
    end

    // Withdrawn request after 10 cycles: no done, previous result kept
    @(negedge clk);
    bus.in1 = 32'd7; bus.in2 = 32'd9; bus.mult_ready = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.mult_ready = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.mult_done) saw_done = 1'b1;
    end
    check("abort10 no done", 64'(saw_done), 64'd0);
    check("abort10 out kept", 64'(bus.out), 64'h540B_E400);
    check("abort10 hi kept",  64'(bus.out_hi), 64'd2);

    // Withdrawal sampled exactly at the completion edge must still abort
    @(negedge clk);
    bus.in1 = 32'd7; bus.in2 = 32'd9; bus.mult_ready = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    bus.mult_ready = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.mult_done) saw_done = 1'b1;
    end
    check("abortlast no done", 64'(saw_done), 64'd0);
    check("abortlast out kept", 64'(bus.out), 64'h540B_E400);

    run_mult(32'd7, 32'd9, 32'd63, 32'd0, 1'b0, "retry7x9");

    // Request held 100 cycles past done: single computation, stable outputs
    @(negedge clk);
    bus.in1 = 32'd3; bus.in2 = 32'd5; bus.mult_ready = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 200 && !saw_done; c++) begin
      @(posedge clk); #1;
      if (bus.mult_done) saw_done = 1'b1;
    end
    check("hold done seen", 64'(saw_done), 64'd1);
    bus.in1 = 32'd2; bus.in2 = 32'd2;
    unstable = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!bus.mult_done || bus.out !== 32'd15) unstable = 1'b1;
    end
    check("hold stable", 64'(unstable), 64'd0);
    check("hold out", 64'(bus.out), 64'd15);
    @(negedge clk);
    bus.mult_ready = 1'b0;
    @(posedge clk); #1;
    check("hold release", 64'(bus.mult_done), 64'd0);

    // Asynchronous reset in the middle of a computation
    @(negedge clk);
    bus.in1 = 32'd11; bus.in2 = 32'd13; bus.mult_ready = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset out",       64'(bus.out),       64'd0);
    check("midreset out_hi",    64'(bus.out_hi),    64'd0);
    check("midreset overflow",  64'(bus.overflow),  64'd0);
    check("midreset mult_done", 64'(bus.mult_done), 64'd0);
    @(negedge clk);
    bus.mult_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_mult(32'd11, 32'd13, 32'd143, 32'd0, 1'b0, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Responder end of the ready/done multiply handshake used by the RSA key-generation blocks (n, phi and similar generators act as initiators).
- Latches two unsigned operands when the initiator raises mult_ready and computes the product by shift-and-add, one bit per cycle.
- Presents the product and raises mult_done, then follows a four-phase release.
- Fixed latency, so initiators and benches can count cycles.

Parameters:
- WIDTH, 32, operand and result width in bits; must be 2 or more.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- mult_ready  input  1  request level from initiator; held high until mult_done seen
- in1  input  WIDTH  multiplicand, sampled on request edge
- in2  input  WIDTH  multiplier, sampled on request edge
- out  output  WIDTH  low WIDTH bits of in1*in2
- out_hi  output  WIDTH  high WIDTH bits of in1*in2
- overflow  output  1  1 when out_hi != 0
- mult_done  output  1  result valid; held until mult_ready low

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; out, out_hi = 0; overflow = 0; mult_done = 0; internal operand, accumulator and counter registers = 0.
- All other updates are on the rising edge of clk, registered outputs only, no combinational path from inputs to outputs.
- States: IDLE, CALC, DONE (2-bit enum).
- IDLE:
  - When mult_ready=1 is sampled at edge E0: a <= zero-extended in1 (2*WIDTH bits), b <= in2, acc <= 0, cnt <= 0, go to CALC.
  - Initiators drive operands and mult_ready from the same edge, so both are valid at E0.
- CALC, each edge:
  - If b[0], acc <= acc + a (2*WIDTH-bit add, no carry loss possible).
  - a <= a << 1; b <= b >> 1; cnt <= cnt + 1.
  - Counter width is $clog2(WIDTH)+1.
- CALC completion:
  - Runs exactly WIDTH iterations, edges E1..E_WIDTH. There is no early exit, even if b reaches 0.
  - At edge E_WIDTH, the final acc value (including that edge's add) is written: out <= acc_next[WIDTH-1:0], out_hi <= acc_next[2W-1:W], overflow <= |acc_next[2W-1:W], mult_done <= 1, go to DONE.
  - Latency: mult_done is visible WIDTH cycles after the request edge (32 for the default).
- CALC abort:
  - If mult_ready=0 is sampled during CALC (initiator withdrew), go to IDLE.
  - out, out_hi and overflow are unchanged; mult_done stays 0.
  - The abort takes priority over completion at edge E_WIDTH.
- DONE:
  - Outputs are held stable while mult_ready=1. A held-high request does not start a new multiply.
  - When mult_ready=0 is sampled: mult_done <= 0, go to IDLE. out, out_hi and overflow keep their last values.
- Back-to-back requests: a new request is accepted at the first edge in IDLE where mult_ready=1. The minimum request-to-request spacing is WIDTH+2 edges.
- in1 and in2 changes after E0 have no effect on the running computation.
- Operand zero gives out=0, out_hi=0, overflow=0 after the full WIDTH cycles.
- Reset mid-operation (any state) returns immediately to reset values. A pending computation is discarded.

Decomposition:
- rsa_pkg holds:
  - mult_state_t enum {IDLE, CALC, DONE}
  - constant RSA_WIDTH = 32, used as the default WIDTH by instantiating blocks
- No sub-module: one state register block, one next-state block and one datapath register block in a single module (about 150 lines).

Test Plan:
- in1=61, in2=53, raise mult_ready and hold -> mult_done rises exactly 32 cycles after the request edge; out=3233 (0x00000CA1), out_hi=0, overflow=0; drop mult_ready -> mult_done=0 one edge later, out still 3233.
- in1=0xFFFFFFFF, in2=2 -> out=0xFFFFFFFE, out_hi=0x00000001, overflow=1.
- in1=0xFFFFFFFF, in2=0xFFFFFFFF -> out=0x00000001, out_hi=0xFFFFFFFE, overflow=1.
- in1=0, in2=12345 -> out=0, overflow=0, latency still 32 cycles.
- Request with 7*9, then drop mult_ready after 10 cycles -> no mult_done pulse, outputs keep previous values; a new request with 7*9 -> out=63 after 32 cycles.
- Two further cases:
  - Hold mult_ready high for 100 cycles after done -> single computation, mult_done held steady.
  - Assert reset_n=0 mid-CALC -> all outputs 0 asynchronously, state IDLE, next request completes normally.
